segasys1_sndlatch: RTL and testbench
====================================

// Module: segasys1_sndlatch
// PURPOSE
// Sound-CPU end of the main->sound command path. Captures each SNDRQ/SNDNO request from the
// main CPU block, queues it in a small FIFO, raises NMI to the sound Z80, serves the command
// byte on sound-CPU reads at $E000-$FFFF, and pops on read completion. Clocked on CLK48M.
// PARAMETERS
// DEPTH_LOG2   2    FIFO depth = 2**DEPTH_LOG2 command bytes
// SYNC_STAGES  2    synchroniser flops on SNDRQ (>=2)
// NMI_GAP      32   CLK48M cycles NMI is held low after each pop (re-arms Z80 edge NMI)
// PORTS
// CLK48M     in   1            system clock, all state on rising edge
// RESET_N    in   1            asynchronous, active-low reset
// SNDRQ      in   1            request pulse from main CPU block (one CPU clock wide, async)
// SNDNO      in   8            command byte; stable from SNDRQ rise until next request
// SCPU_AD    in   16           sound CPU address
// SCPU_MREQ  in   1            sound CPU memory request, active-high
// SCPU_RD    in   1            sound CPU read strobe, active-high
// SCPU_CS    out  1            latch selected: SCPU_AD[15:13]==3'b111 & SCPU_MREQ & SCPU_RD
// SCPU_DO    out  8            command byte to sound CPU data selector
// SCPU_NMI   out  1            NMI request to sound CPU, active-high
// LEVEL      out  DEPTH_LOG2+1 queued command count
// OVF        out  1            sticky: a request was dropped on full FIFO
// BEHAVIOUR
// - Reset (RESET_N low, async): FIFO empty, pointers 0, LEVEL=0, SCPU_DO=8'h00, SCPU_NMI=0,
//   OVF=0, gap counter 0, sync chain 0. Reset mid-operation discards all queued commands.
// - Capture: SNDRQ through SYNC_STAGES flops; push on synced rising edge (last stage & ~prev).
//   SNDNO sampled unsynchronised at push (stable by construction). One push per SNDRQ pulse;
//   requests closer than SYNC_STAGES+2 cycles are not required to be resolved.
// - Latency: SNDRQ rise -> entry written + LEVEL incremented at edge SYNC_STAGES+1 ->
//   SCPU_NMI high one edge later (registered).
// - Read: SCPU_CS is combinational. SCPU_DO = head entry while LEVEL>0, else last popped
//   byte (held). Pop on falling edge of registered SCPU_CS (end of read cycle), so SCPU_DO
//   is stable for the whole read. Read while empty: no pop, LEVEL stays 0.
// - Full: push with LEVEL==DEPTH -> byte dropped, contents unchanged, OVF<=1 until reset.
// - Simultaneous push+pop same cycle: both pointers advance, LEVEL unchanged; at full this
//   is accepted (pop frees the slot), OVF not set. Pointers wrap modulo DEPTH.
// - NMI: SCPU_NMI = (LEVEL!=0) & (gap==0), registered. Each pop loads gap=NMI_GAP, counts
//   down to 0 each cycle; further pops reload. Gives one fresh NMI edge per queued command.
//   Push during gap does not shorten gap.
// - States (NMI control): IDLE (LEVEL==0, NMI low) -> ASSERT (LEVEL>0, gap==0, NMI high)
//   -> GAP on pop (NMI low, count down) -> ASSERT if LEVEL>0 else IDLE when gap hits 0.
// STRUCTURE
// - Shared package segasys1_pkg: SND_LATCH_A15_13 = 3'b111, SND_CMD_W = 8.
// - One sub-module: segasys1_cmdfifo (sync FIFO: push, pop, din, head, level, full, empty;
//   simultaneous push/pop legal at full). Top holds sync, edge detects, decode, NMI counter.
// TESTING
// 1 Reset: RESET_N low mid-queue (LEVEL=2) -> LEVEL=0, SCPU_NMI=0, OVF=0, SCPU_DO=8'h00.
// 2 Single cmd: SNDNO=8'h5A, SNDRQ 16-cycle pulse -> LEVEL=1 at edge 3, NMI high at edge 4;
//   read $E000 -> SCPU_DO=8'h5A throughout; on CS fall LEVEL=0, NMI low, DO holds 8'h5A.
// 3 Queue: push 8'h01,8'h02,8'h03 -> LEVEL=3; three reads return 01,02,03 in order; NMI
//   low exactly 32 cycles after pops 1 and 2, then re-asserts; stays low after pop 3.
// 4 Overflow: push 5 bytes (DEPTH=4) without reads -> LEVEL=4, OVF=1, reads return first 4.
// 5 Simultaneous: FIFO full, SNDRQ edge coincides with read-end -> LEVEL stays 4, OVF=0,
//   new byte read last.
// 6 Decode/empty: reads at $DFFF (CS=0) and at $E000 while empty -> no pop, LEVEL=0, NMI=0.

Source files
------------

// File: rtl/segasys1_pkg.sv
// Shared constants and types for the Sega System 1 sound-command path.
package segasys1_pkg;

    // Sound-CPU window for the command latch: $E000-$FFFF.
    localparam logic [2:0] SND_LATCH_A15_13 = 3'b111;
    localparam int         SND_CMD_W        = 8;

    // NMI control: idle (nothing queued), asserted, or held low after a pop.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } nmi_state_t;

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small synchronous command FIFO; a push at full is accepted when a pop frees the slot.
module segasys1_cmdfifo
    import segasys1_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int W          = SND_CMD_W
) (
    input  logic                  gclk,
    input  logic                  grst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage has no reset; only entries behind the write pointer are ever read.
    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/segasys1_sndlatch.sv
// Sound-CPU side of the main->sound command path: sync, queue, NMI, read-out.
module segasys1_sndlatch
    import segasys1_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int NMI_GAP     = 32
) (
    input  logic                   CLK48M,
    input  logic                   RESET_N,
    input  logic                   SNDRQ,
    input  logic [SND_CMD_W-1:0]   SNDNO,
    input  logic [15:0]            SCPU_AD,
    input  logic                   SCPU_MREQ,
    input  logic                   SCPU_RD,
    output logic                   SCPU_CS,
    output logic [SND_CMD_W-1:0]   SCPU_DO,
    output logic                   SCPU_NMI,
    output logic [DEPTH_LOG2:0]    LEVEL,
    output logic                   OVF
);

    localparam int GAP_W = $clog2(NMI_GAP + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rq_prev_q;
    logic                   cs_q;
    logic                   cs_prev_q;
    logic                   push;
    logic                   pop_eff;
    logic                   full;
    logic                   empty;
    logic [SND_CMD_W-1:0]   head;
    logic [SND_CMD_W-1:0]   last_q;
    logic [GAP_W-1:0]       gap_q;
    logic [GAP_W-1:0]       gap_nxt;
    nmi_state_t             st_q;
    nmi_state_t             st_nxt;
    logic                   unused_ad;

    // Low address bits are don't-care inside the latch window.
    assign unused_ad = ^SCPU_AD[12:0];

    assign SCPU_CS = (SCPU_AD[15:13] == SND_LATCH_A15_13) & SCPU_MREQ & SCPU_RD;
    assign push    = sync_q[SYNC_STAGES-1] & ~rq_prev_q;
    // End of read = falling edge of the registered select; DO stays put for the whole read.
    assign pop_eff = cs_prev_q & ~cs_q & ~empty;
    assign SCPU_DO = empty ? last_q : head;
    assign SCPU_NMI = (st_q == S_ASSERT);

    // Request synchroniser, its edge detector, and the registered chip select.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q    <= '0;
            rq_prev_q <= 1'b0;
            cs_q      <= 1'b0;
            cs_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], SNDRQ};
            rq_prev_q <= sync_q[SYNC_STAGES-1];
            cs_q      <= SCPU_CS;
            cs_prev_q <= cs_q;
        end
    end

    // Last popped byte is held for reads of an empty queue; overflow is sticky.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q <= '0;
            OVF    <= 1'b0;
        end else begin
            if (pop_eff)                 last_q <= head;
            if (push & full & ~pop_eff)  OVF    <= 1'b1;
        end
    end

    segasys1_cmdfifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (SND_CMD_W)
    ) u_fifo (
        .gclk   (CLK48M),
        .grst_n (RESET_N),
        .push   (push),
        .pop    (pop_eff),
        .din    (SNDNO),
        .head   (head),
        .level  (LEVEL),
        .full   (full),
        .empty  (empty)
    );

    // NMI state and gap counter registers.
    always_ff @(posedge CLK48M or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q  <= S_IDLE;
            gap_q <= '0;
        end else begin
            st_q  <= st_nxt;
            gap_q <= gap_nxt;
        end
    end

    // Every pop forces NMI low for NMI_GAP cycles so the Z80 sees a fresh edge per command.
    always_comb begin
        st_nxt  = st_q;
        gap_nxt = gap_q;
        if (gap_q != '0) gap_nxt = gap_q - GAP_W'(1);
        if (pop_eff) begin
            st_nxt  = S_GAP;
            gap_nxt = GAP_W'(NMI_GAP);
        end else begin
            case (st_q)
                S_IDLE:   if (!empty && gap_q == '0) st_nxt = S_ASSERT;
                S_ASSERT: if (empty) st_nxt = S_IDLE;
                S_GAP:    if (gap_q <= GAP_W'(1)) st_nxt = empty ? S_IDLE : S_ASSERT;
                default:  st_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Self-checking bench for segasys1_sndlatch against a queue-based reference model.
module tb_segasys1_sndlatch;

    localparam int DEPTH = 4;

    logic        CLK48M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SNDRQ = 1'b0;
    logic [7:0]  SNDNO = 8'h00;
    logic [15:0] SCPU_AD = 16'h0000;
    logic        SCPU_MREQ = 1'b0;
    logic        SCPU_RD = 1'b0;
    logic        SCPU_CS;
    logic [7:0]  SCPU_DO;
    logic        SCPU_NMI;
    logic [2:0]  LEVEL;
    logic        OVF;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic [7:0] model_last;
    bit         model_ovf;

    segasys1_sndlatch dut (
        .CLK48M    (CLK48M),
        .RESET_N   (RESET_N),
        .SNDRQ     (SNDRQ),
        .SNDNO     (SNDNO),
        .SCPU_AD   (SCPU_AD),
        .SCPU_MREQ (SCPU_MREQ),
        .SCPU_RD   (SCPU_RD),
        .SCPU_CS   (SCPU_CS),
        .SCPU_DO   (SCPU_DO),
        .SCPU_NMI  (SCPU_NMI),
        .LEVEL     (LEVEL),
        .OVF       (OVF)
    );

    always #10 CLK48M = ~CLK48M;

    task automatic apply_reset();
        @(negedge CLK48M);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK48M);
        RESET_N = 1'b1;
        model_q.delete();
        model_last = 8'h00;
        model_ovf  = 1'b0;
        @(negedge CLK48M);
    endtask

    // One request pulse, spaced well beyond the synchroniser resolution window.
    task automatic push_cmd(input logic [7:0] b);
        @(negedge CLK48M);
        SNDNO = b;
        SNDRQ = 1'b1;
        repeat (4) @(negedge CLK48M);
        SNDRQ = 1'b0;
        repeat (3) @(negedge CLK48M);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    // A full read cycle; reports the byte seen, whether CS decoded, and DO stability.
    task automatic do_read(input logic [15:0] addr, output logic [7:0] d,
                           output logic cs_seen, output logic stable);
        @(negedge CLK48M);
        SCPU_AD = addr;
        SCPU_MREQ = 1'b1;
        SCPU_RD = 1'b1;
        #1;
        cs_seen = SCPU_CS;
        d = SCPU_DO;
        stable = 1'b1;
        repeat (3) begin
            @(negedge CLK48M);
            if (SCPU_DO !== d) stable = 1'b0;
        end
        SCPU_MREQ = 1'b0;
        SCPU_RD = 1'b0;
        SCPU_AD = 16'h0000;
        repeat (4) @(negedge CLK48M);
    endtask

    function automatic void model_pop();
        if (model_q.size() > 0) model_last = model_q.pop_front();
    endfunction

    task automatic test_reset();
        apply_reset();
        push_cmd(8'($urandom));
        push_cmd(8'($urandom));
        checks++;
        if (LEVEL !== 3'd2) begin errors++; $display("FAIL reset_prefill LEVEL=%0d exp=2", LEVEL); end
        @(negedge CLK48M);
        RESET_N = 1'b0;
        #1;
        checks++;
        if (LEVEL !== 3'd0 || SCPU_NMI !== 1'b0 || OVF !== 1'b0 || SCPU_DO !== 8'h00) begin
            errors++;
            $display("FAIL reset_state LEVEL=%0d NMI=%b OVF=%b DO=%h exp 0/0/0/00",
                     LEVEL, SCPU_NMI, OVF, SCPU_DO);
        end
        apply_reset();
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic cs, st;
        apply_reset();
        @(negedge CLK48M);
        SNDNO = 8'h5A;
        SNDRQ = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK48M);
            #1;
            if (k == 2) begin
                checks++;
                if (LEVEL !== 3'd0) begin errors++; $display("FAIL single_edge2 LEVEL=%0d exp=0", LEVEL); end
            end
            if (k == 3) begin
                checks++;
                if (LEVEL !== 3'd1 || SCPU_NMI !== 1'b0) begin
                    errors++; $display("FAIL single_edge3 LEVEL=%0d NMI=%b exp 1/0", LEVEL, SCPU_NMI);
                end
            end
            if (k == 4) begin
                checks++;
                if (SCPU_NMI !== 1'b1) begin errors++; $display("FAIL single_edge4 NMI=%b exp=1", SCPU_NMI); end
            end
        end
        repeat (12) @(negedge CLK48M);
        SNDRQ = 1'b0;
        model_q.push_back(8'h5A);
        do_read(16'hE000, d, cs, st);
        model_pop();
        checks++;
        if (d !== 8'h5A || cs !== 1'b1 || st !== 1'b1) begin
            errors++; $display("FAIL single_read DO=%h CS=%b stable=%b exp 5a/1/1", d, cs, st);
        end
        checks++;
        if (LEVEL !== 3'd0 || SCPU_NMI !== 1'b0 || SCPU_DO !== 8'h5A) begin
            errors++; $display("FAIL single_after LEVEL=%0d NMI=%b DO=%h exp 0/0/5a", LEVEL, SCPU_NMI, SCPU_DO);
        end
    endtask

    task automatic test_queue();
        logic [7:0] d;
        logic [2:0] lvl;
        int n, lowcnt;
        bit st;
        apply_reset();
        push_cmd(8'h01);
        push_cmd(8'h02);
        push_cmd(8'h03);
        checks++;
        if (LEVEL !== 3'd3) begin errors++; $display("FAIL queue_level LEVEL=%0d exp=3", LEVEL); end
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (SCPU_NMI !== 1'b1 && n < 20) begin @(negedge CLK48M); n++; end
            lvl = LEVEL;
            @(negedge CLK48M);
            SCPU_AD = 16'hE123;
            SCPU_MREQ = 1'b1;
            SCPU_RD = 1'b1;
            #1;
            d = SCPU_DO;
            st = 1'b1;
            repeat (3) begin @(negedge CLK48M); if (SCPU_DO !== d) st = 1'b0; end
            SCPU_MREQ = 1'b0;
            SCPU_RD = 1'b0;
            n = 0;
            while (LEVEL === lvl && n < 10) begin @(posedge CLK48M); #1; n++; end
            lowcnt = 0;
            while (SCPU_NMI === 1'b0 && lowcnt < 60) begin lowcnt++; @(posedge CLK48M); #1; end
            model_pop();
            checks++;
            if (d !== model_last || st !== 1'b1 || n >= 10) begin
                errors++; $display("FAIL queue_read%0d DO=%h stable=%b exp %h/1", i, d, st, model_last);
            end
            checks++;
            if (lowcnt !== ((i < 2) ? 32 : 60)) begin
                errors++; $display("FAIL queue_nmi_gap%0d low_cycles=%0d exp=%0d", i, lowcnt, (i < 2) ? 32 : 60);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic cs, st;
        apply_reset();
        for (int i = 0; i < 5; i++) push_cmd(8'($urandom));
        checks++;
        if (LEVEL !== 3'd4 || OVF !== 1'b1) begin
            errors++; $display("FAIL ovf_full LEVEL=%0d OVF=%b exp 4/1", LEVEL, OVF);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'hFFFF, d, cs, st);
            checks++;
            if (d !== model_q[0]) begin errors++; $display("FAIL ovf_read%0d DO=%h exp=%h", i, d, model_q[0]); end
            model_pop();
        end
        checks++;
        if (LEVEL !== 3'd0 || OVF !== 1'b1) begin
            errors++; $display("FAIL ovf_drained LEVEL=%0d OVF=%b exp 0/1", LEVEL, OVF);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, nb;
        logic cs, st;
        int minlvl;
        apply_reset();
        for (int i = 0; i < 4; i++) push_cmd(8'($urandom));
        nb = 8'($urandom);
        @(negedge CLK48M);
        SCPU_AD = 16'hE000;
        SCPU_MREQ = 1'b1;
        SCPU_RD = 1'b1;
        #1;
        d = SCPU_DO;
        repeat (2) @(negedge CLK48M);
        SNDNO = nb;
        SNDRQ = 1'b1;
        @(negedge CLK48M);
        SCPU_MREQ = 1'b0;
        SCPU_RD = 1'b0;
        minlvl = 4;
        repeat (6) begin
            @(posedge CLK48M);
            #1;
            if (int'(LEVEL) < minlvl) minlvl = int'(LEVEL);
        end
        @(negedge CLK48M);
        SNDRQ = 1'b0;
        repeat (3) @(negedge CLK48M);
        checks++;
        if (d !== model_q[0]) begin errors++; $display("FAIL simul_read DO=%h exp=%h", d, model_q[0]); end
        model_pop();
        model_q.push_back(nb);
        checks++;
        if (LEVEL !== 3'd4 || OVF !== 1'b0 || minlvl != 4) begin
            errors++; $display("FAIL simul_level LEVEL=%0d min=%0d OVF=%b exp 4/4/0", LEVEL, minlvl, OVF);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'hE000, d, cs, st);
            checks++;
            if (d !== model_q[0]) begin errors++; $display("FAIL simul_drain%0d DO=%h exp=%h", i, d, model_q[0]); end
            model_pop();
        end
    endtask

    task automatic test_decode_empty();
        logic [7:0] d;
        logic cs, st;
        apply_reset();
        do_read(16'hDFFF, d, cs, st);
        checks++;
        if (cs !== 1'b0 || LEVEL !== 3'd0) begin
            errors++; $display("FAIL dec_dfff CS=%b LEVEL=%0d exp 0/0", cs, LEVEL);
        end
        do_read(16'hE000, d, cs, st);
        checks++;
        if (cs !== 1'b1 || d !== 8'h00 || LEVEL !== 3'd0 || SCPU_NMI !== 1'b0) begin
            errors++; $display("FAIL dec_empty CS=%b DO=%h LEVEL=%0d NMI=%b exp 1/00/0/0", cs, d, LEVEL, SCPU_NMI);
        end
        push_cmd(8'hC3);
        do_read(16'hDFFF, d, cs, st);
        checks++;
        if (LEVEL !== 3'd1) begin errors++; $display("FAIL dec_nopop LEVEL=%0d exp=1", LEVEL); end
        do_read(16'hE000, d, cs, st);
        model_pop();
        checks++;
        if (d !== 8'hC3 || LEVEL !== 3'd0) begin
            errors++; $display("FAIL dec_pop DO=%h LEVEL=%0d exp c3/0", d, LEVEL);
        end
    endtask

    task automatic test_random();
        logic [7:0] d, exp_d;
        logic cs, st;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                push_cmd(8'($urandom));
            end else begin
                exp_d = (model_q.size() > 0) ? model_q[0] : model_last;
                do_read(16'hE000 | 16'($urandom_range(0, 16'h1FFF)), d, cs, st);
                model_pop();
                checks++;
                if (d !== exp_d || st !== 1'b1) begin
                    errors++; $display("FAIL rand_read%0d DO=%h stable=%b exp=%h", i, d, st, exp_d);
                end
            end
            checks++;
            if (LEVEL !== 3'(model_q.size()) || OVF !== model_ovf) begin
                errors++; $display("FAIL rand_state%0d LEVEL=%0d OVF=%b exp %0d/%b",
                                   i, LEVEL, OVF, model_q.size(), model_ovf);
            end
        end
    endtask

    initial begin
        model_last = 8'h00;
        model_ovf  = 1'b0;
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_decode_empty();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
